rgb_to_gray_proc: RTL and testbench



---
 rtl/rgb_to_gray_proc_pkg.sv | 28 ++
 rtl/rgb_to_gray_proc_frame_geom_check.sv | 107 ++++++++++
 rtl/rgb_to_gray_proc.sv | 85 ++++++++
 tb/tb_rgb_to_gray_proc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_to_gray_proc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_to_gray_proc_pkg : shared luminance and frame-geometry constants       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package rgb_to_gray_proc_pkg;

   localparam int PIX_W   = 8;
   localparam int ACC_W   = 16;
   localparam int DIM_W   = 11;
   localparam int Y_SHIFT = 8;

   localparam logic [PIX_W-1:0] COEF_R  = 8'd77;
   localparam logic [PIX_W-1:0] COEF_G  = 8'd150;
   localparam logic [PIX_W-1:0] COEF_B  = 8'd29;
   localparam logic [ACC_W-1:0] ROUND_C = 16'd128;

   typedef logic [DIM_W-1:0] dim_t;

   localparam dim_t DIM_MAX = '1;

   // Counters stick at all-ones so an overlong frame still reads as wrong.
   function automatic dim_t sat_inc(input dim_t v);
      return (v == DIM_MAX) ? v : v + dim_t'(1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_to_gray_proc_frame_geom_check.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | frame_geom_check : per-frame line length / line count checker              |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module frame_geom_check
   import rgb_to_gray_proc_pkg::*;
#(
   parameter logic [DIM_W-1:0] IMG_HDISP = 11'd400,
   parameter logic [DIM_W-1:0] IMG_VDISP = 11'd300
) (
   input  logic clk,
   input  logic rst,
   input  logic per_img_vsync,
   input  logic per_img_href,
   output logic frame_done,
   output logic frame_err
);

   logic vsync_prev_q, vsync_prev_d;
   logic href_prev_q,  href_prev_d;
   logic prev_valid_q, prev_valid_d;
   logic armed_q,      armed_d;
   dim_t pix_cnt_q,    pix_cnt_d;
   dim_t line_cnt_q,   line_cnt_d;
   logic line_bad_q,   line_bad_d;
   logic frame_done_q, frame_done_d;
   logic frame_err_q,  frame_err_d;

   logic vs_rise;
   logic vs_fall;
   logic hr_fall;
   logic line_end;

   always_comb begin
      // No rise is reported until one real sample has been seen after reset,
      // so a frame interrupted by reset is never evaluated.
      vs_rise  = prev_valid_q & per_img_vsync & ~vsync_prev_q;
      vs_fall  = vsync_prev_q & ~per_img_vsync;
      hr_fall  = href_prev_q & ~per_img_href;
      line_end = hr_fall & armed_q;

      vsync_prev_d = per_img_vsync;
      href_prev_d  = per_img_href;
      prev_valid_d = 1'b1;

      armed_d = armed_q;
      if (vs_rise) begin
         armed_d = 1'b1;
      end else if (vs_fall) begin
         armed_d = 1'b0;
      end

      pix_cnt_d = pix_cnt_q;
      if (hr_fall) begin
         pix_cnt_d = '0;
      end else if (per_img_href) begin
         pix_cnt_d = sat_inc(pix_cnt_q);
      end

      line_cnt_d = line_cnt_q;
      line_bad_d = line_bad_q;
      if (vs_rise) begin
         line_cnt_d = '0;
         line_bad_d = 1'b0;
      end else if (line_end) begin
         line_cnt_d = sat_inc(line_cnt_q);
         line_bad_d = line_bad_q | (pix_cnt_q != IMG_HDISP);
      end

      // The _d values already include a line ending on the same cycle.
      frame_done_d = vs_fall & armed_q;
      frame_err_d  = frame_err_q;
      if (frame_done_d) begin
         frame_err_d = line_bad_d | (line_cnt_d != IMG_VDISP);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vsync_prev_q <= 1'b0;
         href_prev_q  <= 1'b0;
         prev_valid_q <= 1'b0;
         armed_q      <= 1'b0;
         pix_cnt_q    <= '0;
         line_cnt_q   <= '0;
         line_bad_q   <= 1'b0;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         vsync_prev_q <= vsync_prev_d;
         href_prev_q  <= href_prev_d;
         prev_valid_q <= prev_valid_d;
         armed_q      <= armed_d;
         pix_cnt_q    <= pix_cnt_d;
         line_cnt_q   <= line_cnt_d;
         line_bad_q   <= line_bad_d;
         frame_done_q <= frame_done_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign frame_done = frame_done_q;
   assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: rtl/rgb_to_gray_proc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rgb_to_gray_proc : RGB888 to 8-bit luminance, 3-stage pipeline + checker   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module rgb_to_gray_proc
   import rgb_to_gray_proc_pkg::*;
#(
   parameter logic [DIM_W-1:0] IMG_HDISP = 11'd400,
   parameter logic [DIM_W-1:0] IMG_VDISP = 11'd300
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             per_img_vsync,
   input  logic             per_img_href,
   input  logic [PIX_W-1:0] per_img_red,
   input  logic [PIX_W-1:0] per_img_green,
   input  logic [PIX_W-1:0] per_img_blue,
   output logic             post_img_vsync,
   output logic             post_img_href,
   output logic [PIX_W-1:0] post_img_gray,
   output logic             frame_done,
   output logic             frame_err
);

   logic [ACC_W-1:0] prod_r_q, prod_r_d;
   logic [ACC_W-1:0] prod_g_q, prod_g_d;
   logic [ACC_W-1:0] prod_b_q, prod_b_d;
   logic [ACC_W-1:0] sum_q,    sum_d;
   logic [PIX_W-1:0] gray_q,   gray_d;
   logic [2:0]       vsync_sr_q, vsync_sr_d;
   logic [2:0]       href_sr_q,  href_sr_d;

   always_comb begin
      prod_r_d = ACC_W'(per_img_red)   * ACC_W'(COEF_R);
      prod_g_d = ACC_W'(per_img_green) * ACC_W'(COEF_G);
      prod_b_d = ACC_W'(per_img_blue)  * ACC_W'(COEF_B);

      // Coefficients sum to 256, so the rounded sum tops out at 65408.
      sum_d = prod_r_q + prod_g_q + prod_b_q + ROUND_C;

      gray_d = href_sr_q[1] ? sum_q[Y_SHIFT +: PIX_W] : '0;

      vsync_sr_d = {vsync_sr_q[1:0], per_img_vsync};
      href_sr_d  = {href_sr_q[1:0],  per_img_href};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_r_q   <= '0;
         prod_g_q   <= '0;
         prod_b_q   <= '0;
         sum_q      <= '0;
         gray_q     <= '0;
         vsync_sr_q <= '0;
         href_sr_q  <= '0;
      end else begin
         prod_r_q   <= prod_r_d;
         prod_g_q   <= prod_g_d;
         prod_b_q   <= prod_b_d;
         sum_q      <= sum_d;
         gray_q     <= gray_d;
         vsync_sr_q <= vsync_sr_d;
         href_sr_q  <= href_sr_d;
      end
   end

   assign post_img_vsync = vsync_sr_q[2];
   assign post_img_href  = href_sr_q[2];
   assign post_img_gray  = gray_q;

   frame_geom_check #(
      .IMG_HDISP (IMG_HDISP),
      .IMG_VDISP (IMG_VDISP)
   ) u_geom (
      .clk           (clk),
      .rst           (rst),
      .per_img_vsync (per_img_vsync),
      .per_img_href  (per_img_href),
      .frame_done    (frame_done),
      .frame_err     (frame_err)
   );

endmodule
`default_nettype wire

// File: tb/tb_rgb_to_gray_proc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_rgb_to_gray_proc : scoreboard bench for rgb_to_gray_proc                |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_rgb_to_gray_proc;

   localparam int H = 20;
   localparam int V = 12;

   logic       clk;
   logic       rst;
   logic       per_img_vsync;
   logic       per_img_href;
   logic [7:0] per_img_red;
   logic [7:0] per_img_green;
   logic [7:0] per_img_blue;
   logic       post_img_vsync;
   logic       post_img_href;
   logic [7:0] post_img_gray;
   logic       frame_done;
   logic       frame_err;

   rgb_to_gray_proc #(
      .IMG_HDISP (11'(H)),
      .IMG_VDISP (11'(V))
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .per_img_vsync  (per_img_vsync),
      .per_img_href   (per_img_href),
      .per_img_red    (per_img_red),
      .per_img_green  (per_img_green),
      .per_img_blue   (per_img_blue),
      .post_img_vsync (post_img_vsync),
      .post_img_href  (post_img_href),
      .post_img_gray  (post_img_gray),
      .frame_done     (frame_done),
      .frame_err      (frame_err)
   );

   typedef struct {
      int cyc;
      int val;
   } exp_t;

   exp_t gq[$];
   exp_t fq[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   hold_err = 0;
   bit   hist_v [8];
   bit   hist_h [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int luma(input int r, input int g, input int b);
      return (77 * r + 150 * g + 29 * b + 128) / 256;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic drive(input bit v, input bit h, input int r, input int g, input int b);
      @(negedge clk);
      per_img_vsync = v;
      per_img_href  = h;
      per_img_red   = 8'(r);
      per_img_green = 8'(g);
      per_img_blue  = 8'(b);
      if (h) gq.push_back('{cyc + 1, luma(r, g, b)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 0, 0, 0);
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b1;
      gq.delete();
      fq.delete();
      #1;
      check("async_rst_vsync", int'(post_img_vsync), 0);
      check("async_rst_href",  int'(post_img_href), 0);
      check("async_rst_gray",  int'(post_img_gray), 0);
      check("async_rst_done",  int'(frame_done), 0);
      check("async_rst_err",   int'(frame_err), 0);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
   endtask

   // Expected frame status follows directly from the line lengths sent.
   task automatic send_frame(input int nlines, input int odd_line, input int odd_len,
                             input int rst_line);
      int len;
      int err;
      err = (nlines != V) || (odd_line >= 0 && odd_line < nlines && odd_len != H);
      drive(1'b1, 1'b0, 0, 0, 0);
      drive(1'b1, 1'b0, 0, 0, 0);
      for (int l = 0; l < nlines; l++) begin
         len = (l == odd_line) ? odd_len : H;
         for (int p = 0; p < len; p++) begin
            if (l == rst_line && p == 7) reset_pulse();
            drive(1'b1, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)));
         end
         if (l != nlines - 1) drive(1'b1, 1'b0, 0, 0, 0);
      end
      // Last line ends on the same cycle vsync drops.
      drive(1'b0, 1'b0, 0, 0, 0);
      if (rst_line < 0) fq.push_back('{cyc + 1, err});
      idle(3);
   endtask

   // Monitor: DUT outputs after edge c reflect the inputs sampled at edge c-2.
   initial begin : monitor
      exp_t e;
      int   hidx;
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            for (int i = 0; i < 8; i++) begin
               hist_v[i] = 1'b0;
               hist_h[i] = 1'b0;
            end
         end else begin
            hist_v[cyc % 8] = per_img_vsync;
            hist_h[cyc % 8] = per_img_href;
         end
         #1;
         if (rst) begin
            hold_err = 0;
            check("rst_vsync", int'(post_img_vsync), 0);
            check("rst_href",  int'(post_img_href), 0);
            check("rst_gray",  int'(post_img_gray), 0);
            check("rst_done",  int'(frame_done), 0);
            check("rst_err",   int'(frame_err), 0);
         end else begin
            hidx = (cyc + 6) % 8;
            check("vsync_delay", int'(post_img_vsync), int'(hist_v[hidx]));
            check("href_delay",  int'(post_img_href),  int'(hist_h[hidx]));
            if (post_img_href) begin
               if (gq.size() == 0) begin
                  check("gray_unexpected", 1, 0);
               end else begin
                  e = gq.pop_front();
                  check("gray_value",   int'(post_img_gray), e.val);
                  check("gray_latency", cyc - 2, e.cyc);
               end
            end else begin
               check("gray_gap_zero", int'(post_img_gray), 0);
            end
            if (fq.size() > 0 && fq[0].cyc == cyc) begin
               e = fq.pop_front();
               check("frame_done_pulse", int'(frame_done), 1);
               hold_err = e.val;
            end else begin
               check("frame_done_idle", int'(frame_done), 0);
            end
            check("frame_err", int'(frame_err), hold_err);
         end
      end
   end

   initial begin : watchdog
      #(60000 * 10);
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      rst           = 1'b1;
      per_img_vsync = 1'b0;
      per_img_href  = 1'b0;
      per_img_red   = '0;
      per_img_green = '0;
      per_img_blue  = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      idle(3);

      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 255, 255, 255);
      for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 0, 0, 0);
      idle(3);

      drive(1'b0, 1'b1, 255, 0, 0);   idle(1);
      drive(1'b0, 1'b1, 0, 255, 0);   idle(1);
      drive(1'b0, 1'b1, 0, 0, 255);   idle(1);
      drive(1'b0, 1'b1, 128, 128, 128);
      idle(3);

      send_frame(V,     -1, 0,     -1);
      send_frame(V,      5, H - 1, -1);
      send_frame(V + 1, -1, 0,     -1);
      send_frame(V,     -1, 0,     -1);
      send_frame(V,      3, H + 1, -1);

      for (int i = 0; i < 3; i++)
         drive(1'b0, 1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 255)));
      idle(3);

      send_frame(V, -1, 0, 4);
      send_frame(V, -1, 0, -1);
      idle(6);

      check("gray_queue_drained",  gq.size(), 0);
      check("frame_queue_drained", fq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
